// File: rtl/vend_pkg.sv
// Shared definitions for the vending display / sale sequencer.
// Holds sale FSM encoding, 7-segment constants and parameter defaults.
package vend_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DISP = 2'd1,
        CHG  = 2'd2,
        DONE = 2'd3
    } sale_state_t;

    localparam int SCAN_DIV_DEF = 1000;
    localparam int DISP_CYC_DEF = 50000;

    // Segment order {g,f,e,d,c,b,a}, active-high.
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_E     = 7'h79;
    localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/vend_display_seg7_decode.sv
// Combinational BCD to 7-segment decoder; codes 10-15 show 'E'.
// Ports: digit (4-bit BCD in), seg (7-bit {g,f,e,d,c,b,a} out).
module seg7_decode
    import vend_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_E;
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_E;
        endcase
    end

endmodule

// File: rtl/vend_display.sv
// Two-digit multiplexed credit display plus dispense/change strobe sequencer.
// Ports: ck, reset (sync, active-low), ten/single (BCD credit), payok,
//        change (controller levels); seg, an, dispense, chg_out (registered).
module vend_display
    import vend_pkg::*;
#(
    parameter int SCAN_DIV = SCAN_DIV_DEF,
    parameter int DISP_CYC = DISP_CYC_DEF
) (
    input  logic       ck,
    input  logic       reset,
    input  logic [3:0] ten,
    input  logic [3:0] single,
    input  logic       payok,
    input  logic       change,
    output logic [6:0] seg,
    output logic [1:0] an,
    output logic       dispense,
    output logic       chg_out
);

    localparam logic [15:0] SCAN_LAST  = 16'(SCAN_DIV - 1);
    localparam logic [19:0] PULSE_LOAD = 20'(DISP_CYC - 1);

    // Input sampling stage
    logic [3:0] ten_s1;
    logic [3:0] single_s1;
    logic       payok_s1;
    logic       change_s1;
    logic       payok_prev;

    // Display scan
    logic [15:0] scan_cnt;
    logic        dsel;

    // Sale sequencer
    sale_state_t state;
    sale_state_t state_nx;
    logic [19:0] pulse_cnt;
    logic [19:0] pulse_nx;
    logic        chg_req;
    logic        req_nx;

    logic       pay_rise;
    logic [3:0] digit;
    logic [6:0] dec_seg;
    logic       blank_tens;
    logic [6:0] seg_nx;
    logic [1:0] an_nx;

    assign pay_rise = payok_s1 & ~payok_prev;

    always_comb begin
        state_nx = state;
        pulse_nx = pulse_cnt;
        req_nx   = chg_req;
        unique case (state)
            IDLE: begin
                if (pay_rise) begin
                    state_nx = DISP;
                    pulse_nx = PULSE_LOAD;
                    req_nx   = change_s1;
                end
            end
            DISP: begin
                if (pulse_cnt == 20'd0) begin
                    if (chg_req) begin
                        state_nx = CHG;
                        pulse_nx = PULSE_LOAD;
                    end else begin
                        state_nx = DONE;
                    end
                end else begin
                    pulse_nx = pulse_cnt - 20'd1;
                end
            end
            CHG: begin
                if (pulse_cnt == 20'd0) begin
                    state_nx = DONE;
                end else begin
                    pulse_nx = pulse_cnt - 20'd1;
                end
            end
            DONE: begin
                if (!payok_s1) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // One shared decoder; the mux in front picks the digit for this slot.
    assign digit = dsel ? ten_s1 : single_s1;

    seg7_decode u_dec (
        .digit (digit),
        .seg   (dec_seg)
    );

    // Tens digit is suppressed for a leading zero and for the whole sale.
    assign blank_tens = (ten_s1 == 4'd0) || (state != IDLE);

    always_comb begin
        seg_nx = dec_seg;
        an_nx  = 2'b01;
        if (dsel) begin
            if (blank_tens) begin
                seg_nx = SEG_BLANK;
                an_nx  = 2'b00;
            end else begin
                an_nx  = 2'b10;
            end
        end
    end

    always_ff @(posedge ck) begin
        if (!reset) begin
            ten_s1     <= 4'd0;
            single_s1  <= 4'd0;
            payok_s1   <= 1'b0;
            change_s1  <= 1'b0;
            payok_prev <= 1'b0;
            scan_cnt   <= 16'd0;
            dsel       <= 1'b0;
            state      <= IDLE;
            pulse_cnt  <= 20'd0;
            chg_req    <= 1'b0;
            seg        <= SEG_BLANK;
            an         <= 2'b00;
            dispense   <= 1'b0;
            chg_out    <= 1'b0;
        end else begin
            ten_s1     <= ten;
            single_s1  <= single;
            payok_s1   <= payok;
            change_s1  <= change;
            payok_prev <= payok_s1;
            if (scan_cnt == SCAN_LAST) begin
                scan_cnt <= 16'd0;
                dsel     <= ~dsel;
            end else begin
                scan_cnt <= scan_cnt + 16'd1;
            end
            state      <= state_nx;
            pulse_cnt  <= pulse_nx;
            chg_req    <= req_nx;
            seg        <= seg_nx;
            an         <= an_nx;
            dispense   <= (state == DISP);
            chg_out    <= (state == CHG);
        end
    end

endmodule

// File: doc/vend_display.md
VEND_DISPLAY -- requirements
Module: vend_display

Interface
REQ-001 Parameter SCAN_DIV, default 1000: ck cycles per display digit slot; legal range 2..65535.
REQ-002 Parameter DISP_CYC, default 50000: ck cycles for the dispense pulse and for the change pulse; legal range 2..2^20.
REQ-003 ck  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset, sampled on rising edge of ck.
REQ-005 ten  input  4  tens digit of credit from the vending controller, BCD.
REQ-006 single  input  4  units digit of credit from the vending controller, BCD (0 or 5 in normal use).
REQ-007 payok  input  1  level, high while the controller reports a completed sale.
REQ-008 change  input  1  level, high while the controller reports that change is owed.
REQ-009 seg  output  7  segment drive {g,f,e,d,c,b,a}, active-high, registered.
REQ-010 an  output  2  digit enable, one-hot or zero, active-high; an[0] = units, an[1] = tens; registered.
REQ-011 dispense  output  1  product-release strobe, registered.
REQ-012 chg_out  output  1  change-release strobe, registered.

Function
REQ-013 All four inputs ten, single, payok and change shall be registered once (stage S1) before use; S1 also holds the previous payok for edge detection.
REQ-014 Scan counter: 0..SCAN_DIV-1, increments every cycle; wraps to 0 and toggles digit select on reaching SCAN_DIV-1.
REQ-015 Digit select 0 -> an=2'b01, seg=decode(S1 single); digit select 1 -> an=2'b10, seg=decode(S1 ten); an/seg update one cycle after the select changes.
REQ-016 Leading-zero blanking: when S1 ten==0 and digit select==1, an=2'b00 and seg=7'h00.
REQ-017 Decode: 0-9 map to standard segments (0=7'h3F, 5=7'h6D, 3=7'h4F, 2=7'h5B, 1=7'h06); 10-15 shall all display 'E' (7'h79).
REQ-018 Sale FSM states: IDLE, DISP, CHG, DONE.
REQ-019 IDLE: dispense=0, chg_out=0; on a payok rising edge in S1, go to DISP, latch chg_req = S1 change, and load the pulse counter with DISP_CYC-1.
REQ-020 DISP: dispense=1 for exactly DISP_CYC cycles; at count 0, go to CHG if chg_req==1 (reload counter), otherwise go to DONE.
REQ-021 CHG: chg_out=1 for exactly DISP_CYC cycles, then go to DONE.
REQ-022 DONE: both strobes 0; stay while S1 payok==1; go to IDLE when S1 payok==0.
REQ-023 A payok rising edge in any state other than IDLE shall be ignored.
REQ-024 A payok fall during DISP or CHG shall not shorten the pulse; the FSM passes through DONE to IDLE on the following cycle.
REQ-025 While in DISP, CHG or DONE, the display shall blank the tens digit and show the units digit only (an=2'b01 slot; an=2'b00 in the tens slot).
REQ-026 Changes to change after the latch point shall not affect chg_req.
REQ-027 Latency: a payok rise at the inputs shall give dispense=1 on the 3rd rising edge after it (S1, edge detect/state, output register).

Reset
REQ-028 While reset==0 at a rising edge: the FSM goes to IDLE; scan counter, pulse counter, digit select, chg_req and all S1 registers go to 0; seg=7'h00, an=2'b00, dispense=0, chg_out=0.
REQ-029 Reset asserted mid-DISP or mid-CHG shall drop the strobe on the same edge; after release, S1 payok reads 0, so a payok still high at release is seen as a fresh rising edge.

Structure
REQ-030 Package vend_pkg shall hold the FSM state encoding, the segment constants (digits 0-9, 'E', blank) and the SCAN_DIV/DISP_CYC defaults.
REQ-031 Sub-module seg7_decode (purely combinational, 4-bit in, 7-bit out) shall implement REQ-017 and be instantiated once.

Verification (bench uses SCAN_DIV=4, DISP_CYC=8)
REQ-032 ten=2, single=5, payok=0 -> an alternates 01/10 every 4 cycles; seg is 7'h6D in the units slot and 7'h5B in the tens slot.
REQ-033 ten=0, single=5 -> the tens slot shows an=00, seg=00; ten=4'hC -> the tens slot shows seg=7'h79.
REQ-034 payok rises with change=0 -> dispense high for exactly 8 cycles starting at the 3rd edge; chg_out never asserts; FSM stays in DONE until payok falls.
REQ-035 payok rises with change=1 -> 8 cycles of dispense, then 8 cycles of chg_out with no gap or overlap; change is dropped mid-pulse with no effect.
REQ-036 reset=0 asserted on the 4th cycle of dispense with payok held high -> dispense=0 at that edge; after release, a full 8-cycle dispense restarts.
REQ-037 A second payok pulse during CHG is ignored; payok falls during DISP -> pulse completes and the FSM reaches IDLE one cycle after leaving CHG or DISP.
